// File: rtl/ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_pkg
// Brief    : Shared state encoding and bus constants for the RAM arbiter.
// Revision : 1.0
// ============================================================================
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned c_starve_limit_default = 4;

    localparam logic [31:0] c_zero_word     = 32'h0000_0000;
    localparam logic        c_chip_enable   = 1'b1;
    localparam logic        c_chip_disable  = 1'b0;
    localparam logic        c_write_disable = 1'b0;
    localparam logic [3:0]  c_sel_word      = 4'b1111;
    localparam logic [3:0]  c_sel_none      = 4'b0000;

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter_if
// Brief    : Data port, fetch port, RAM side and stall signals of the arbiter.
// Revision : 1.0
// ============================================================================
interface ram_arbiter_if;

    logic        d_ce_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_data_i;
    logic [31:0] d_data_o;
    logic        d_done_o;

    logic        i_ce_i;
    logic [31:0] i_addr_i;
    logic [31:0] i_data_o;
    logic        i_done_o;

    logic        ram_ce_o;
    logic        ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;
    logic        ram_data_ready;

    logic        stallreq_mem_o;
    logic        stallreq_if_o;

    modport slave (
        input  d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
        input  i_ce_i, i_addr_i,
        input  ram_data_i, ram_data_ready,
        output d_data_o, d_done_o, i_data_o, i_done_o,
        output ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o,
        output stallreq_mem_o, stallreq_if_o
    );

    modport master (
        output d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
        output i_ce_i, i_addr_i,
        output ram_data_i, ram_data_ready,
        input  d_data_o, d_done_o, i_data_o, i_done_o,
        input  ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o,
        input  stallreq_mem_o, stallreq_if_o
    );

endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Shares one RAM between the data port and the fetch port, with a
//            starvation counter that forces a fetch grant after a data burst.
// Revision : 1.0
// ============================================================================
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = c_starve_limit_default
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    state_t            r_state,     w_state;
    logic [CNT_W-1:0]  r_cnt,       w_cnt;
    logic              r_ram_ce,    w_ram_ce;
    logic              r_ram_we,    w_ram_we;
    logic [3:0]        r_ram_sel,   w_ram_sel;
    logic [31:0]       r_ram_addr,  w_ram_addr;
    logic [31:0]       r_ram_wdata, w_ram_wdata;
    logic [31:0]       r_d_rdata,   w_d_rdata;
    logic [31:0]       r_i_rdata,   w_i_rdata;
    logic              r_d_done,    w_d_done;
    logic              r_i_done,    w_i_done;
    logic              w_at_limit;

    assign w_at_limit = (r_cnt == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ram_ce    <= c_chip_disable;
            r_ram_we    <= c_write_disable;
            r_ram_sel   <= c_sel_none;
            r_ram_addr  <= c_zero_word;
            r_ram_wdata <= c_zero_word;
            r_d_rdata   <= c_zero_word;
            r_i_rdata   <= c_zero_word;
            r_d_done    <= 1'b0;
            r_i_done    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_ram_ce    <= w_ram_ce;
            r_ram_we    <= w_ram_we;
            r_ram_sel   <= w_ram_sel;
            r_ram_addr  <= w_ram_addr;
            r_ram_wdata <= w_ram_wdata;
            r_d_rdata   <= w_d_rdata;
            r_i_rdata   <= w_i_rdata;
            r_d_done    <= w_d_done;
            r_i_done    <= w_i_done;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_ram_ce    = r_ram_ce;
        w_ram_we    = r_ram_we;
        w_ram_sel   = r_ram_sel;
        w_ram_addr  = r_ram_addr;
        w_ram_wdata = r_ram_wdata;
        w_d_rdata   = r_d_rdata;
        w_i_rdata   = r_i_rdata;
        w_d_done    = 1'b0;
        w_i_done    = 1'b0;

        case (r_state)
            IDLE: begin
                // Data has priority until the fetch side has waited STARVE_LIMIT grants.
                if (bus.d_ce_i && !(bus.i_ce_i && w_at_limit)) begin
                    w_state     = BUSY_D;
                    w_ram_ce    = c_chip_enable;
                    w_ram_we    = bus.d_we_i;
                    w_ram_sel   = bus.d_sel_i;
                    w_ram_addr  = bus.d_addr_i;
                    w_ram_wdata = bus.d_data_i;
                    if (!bus.i_ce_i) begin
                        w_cnt = '0;
                    end else if (!w_at_limit) begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end else if (bus.i_ce_i) begin
                    w_state     = BUSY_I;
                    w_ram_ce    = c_chip_enable;
                    w_ram_we    = c_write_disable;
                    w_ram_sel   = c_sel_word;
                    w_ram_addr  = bus.i_addr_i;
                    w_ram_wdata = c_zero_word;
                    w_cnt       = '0;
                end else begin
                    w_cnt = '0;
                end
            end
            BUSY_D: begin
                if (bus.ram_data_ready) begin
                    w_state   = DONE;
                    w_ram_ce  = c_chip_disable;
                    w_ram_we  = c_write_disable;
                    w_d_rdata = bus.ram_data_i;
                    w_d_done  = 1'b1;
                end
            end
            BUSY_I: begin
                if (bus.ram_data_ready) begin
                    w_state   = DONE;
                    w_ram_ce  = c_chip_disable;
                    w_ram_we  = c_write_disable;
                    w_i_rdata = bus.ram_data_i;
                    w_i_done  = 1'b1;
                end
            end
            DONE: begin
                // Turnaround cycle: the done pulse is visible, no new grant yet.
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign bus.ram_ce_o   = r_ram_ce;
    assign bus.ram_we_o   = r_ram_we;
    assign bus.ram_sel_o  = r_ram_sel;
    assign bus.ram_addr_o = r_ram_addr;
    assign bus.ram_data_o = r_ram_wdata;
    assign bus.d_data_o   = r_d_rdata;
    assign bus.i_data_o   = r_i_rdata;
    assign bus.d_done_o   = r_d_done;
    assign bus.i_done_o   = r_i_done;

    assign bus.stallreq_mem_o = bus.d_ce_i & ~r_d_done;
    assign bus.stallreq_if_o  = bus.i_ce_i & ~r_i_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed vector table plus hand-written corner sequences.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if bus();

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        port;       // 0 = data, 1 = fetch
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;      // extra busy cycles before RAM ready
        int          exp_lat;    // request cycle through done cycle, inclusive
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[6];

    logic [31:0] e_d_data = 32'h0;
    logic [31:0] e_i_data = 32'h0;
    bit          e_d_known = 1'b1;

    task automatic run_vec(input vec_t v, input string tag);
        int n_busy;
        int lat;
        bit seen;
        int hold_err;
        n_busy = 0; lat = 0; seen = 1'b0; hold_err = 0;
        if (v.port == 1'b0) begin
            bus.d_ce_i = 1'b1; bus.d_we_i = v.we; bus.d_sel_i = v.sel;
            bus.d_addr_i = v.addr; bus.d_data_i = v.wdata;
        end else begin
            bus.i_ce_i = 1'b1; bus.i_addr_i = v.addr;
        end
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if ((v.port ? bus.i_done_o : bus.d_done_o) === 1'b1) begin
                seen = 1'b1;
                lat  = c + 1;
            end else begin
                n_busy++;
                if (bus.ram_ce_o !== 1'b1 || bus.ram_we_o !== v.exp_we ||
                    bus.ram_sel_o !== v.exp_sel || bus.ram_addr_o !== v.addr ||
                    bus.ram_data_o !== v.exp_wdata ||
                    (v.port ? bus.stallreq_if_o : bus.stallreq_mem_o) !== 1'b1)
                    hold_err++;
                bus.ram_data_ready = (n_busy == v.delay + 1);
                bus.ram_data_i     = (n_busy == v.delay + 1) ? v.rdata : (32'hBAD0_0000 | n_busy);
            end
        end
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " ram_hold_errors"}, hold_err, 0);
        check({tag, " ram_ce_after"}, {31'b0, bus.ram_ce_o}, 32'd0);
        check({tag, " ram_we_after"}, {31'b0, bus.ram_we_o}, 32'd0);
        check({tag, " stallreq_on_done"},
              {31'b0, (v.port ? bus.stallreq_if_o : bus.stallreq_mem_o)}, 32'd0);
        if (v.port == 1'b0) begin
            if (!v.we) check({tag, " d_data"}, bus.d_data_o, v.rdata);
            check({tag, " i_data_unchanged"}, bus.i_data_o, e_i_data);
            check({tag, " i_done_quiet"}, {31'b0, bus.i_done_o}, 32'd0);
            e_d_data  = v.rdata;
            e_d_known = !v.we;
            bus.d_ce_i = 1'b0;
        end else begin
            check({tag, " i_data"}, bus.i_data_o, v.rdata);
            if (e_d_known) check({tag, " d_data_unchanged"}, bus.d_data_o, e_d_data);
            check({tag, " d_done_quiet"}, {31'b0, bus.d_done_o}, 32'd0);
            e_i_data   = v.rdata;
            bus.i_ce_i = 1'b0;
        end
        bus.ram_data_ready = 1'b0;
        @(negedge clk);
        check({tag, " done_single_pulse"}, {31'b0, (v.port ? bus.i_done_o : bus.d_done_o)}, 32'd0);
    endtask

    initial begin
        int run1, run2, fetches, stray;
        logic prev_ce;

        //          port we  sel      addr          wdata         rdata         dly lat we   sel      wdata
        vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 0, 3,  1'b0, 4'hF, 32'h0000_0000};
        vecs[1] = '{1'b0, 1'b1, 4'h3, 32'h0000_0024, 32'h0000_ABCD, 32'h5555_5555, 2, 5,  1'b1, 4'h3, 32'h0000_ABCD};
        vecs[2] = '{1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0000_0000, 32'h1357_9BDF, 0, 3,  1'b0, 4'hF, 32'h0000_0000};
        vecs[3] = '{1'b0, 1'b0, 4'h6, 32'h0000_0040, 32'hFFFF_0000, 32'hCAFE_F00D, 7, 10, 1'b0, 4'h6, 32'hFFFF_0000};
        vecs[4] = '{1'b1, 1'b0, 4'h0, 32'h0000_0204, 32'h0000_0000, 32'h0BAD_C0DE, 3, 6,  1'b0, 4'hF, 32'h0000_0000};
        vecs[5] = '{1'b0, 1'b1, 4'hC, 32'h0000_0080, 32'h1234_5678, 32'h0F0F_0F0F, 1, 4,  1'b1, 4'hC, 32'h1234_5678};

        bus.d_ce_i = 1'b0; bus.d_we_i = 1'b0; bus.d_sel_i = 4'h0;
        bus.d_addr_i = 32'h0; bus.d_data_i = 32'hA5A5_A5A5;
        bus.i_ce_i = 1'b0; bus.i_addr_i = 32'h0;
        bus.ram_data_i = 32'h0; bus.ram_data_ready = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst ram_ce",   {31'b0, bus.ram_ce_o}, 32'd0);
        check("rst ram_we",   {31'b0, bus.ram_we_o}, 32'd0);
        check("rst ram_sel",  {28'b0, bus.ram_sel_o}, 32'd0);
        check("rst ram_addr", bus.ram_addr_o, 32'd0);
        check("rst ram_data", bus.ram_data_o, 32'd0);
        check("rst d_data",   bus.d_data_o, 32'd0);
        check("rst i_data",   bus.i_data_o, 32'd0);
        check("rst d_done",   {31'b0, bus.d_done_o}, 32'd0);
        check("rst i_done",   {31'b0, bus.i_done_o}, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

        // Contention: data first, fetch waits and gets the next IDLE slot.
        bus.d_ce_i = 1'b1; bus.d_we_i = 1'b0; bus.d_sel_i = 4'hF; bus.d_addr_i = 32'h500;
        bus.i_ce_i = 1'b1; bus.i_addr_i = 32'h600;
        @(negedge clk);
        check("cont data_granted_addr", bus.ram_addr_o, 32'h500);
        check("cont stall_if_busy", {31'b0, bus.stallreq_if_o}, 32'd1);
        bus.ram_data_ready = 1'b1; bus.ram_data_i = 32'h1111_2222;
        @(negedge clk);
        check("cont d_done", {31'b0, bus.d_done_o}, 32'd1);
        check("cont d_data", bus.d_data_o, 32'h1111_2222);
        check("cont stall_if_done", {31'b0, bus.stallreq_if_o}, 32'd1);
        bus.d_ce_i = 1'b0; bus.ram_data_ready = 1'b0;
        @(negedge clk);
        check("cont idle_ce", {31'b0, bus.ram_ce_o}, 32'd0);
        check("cont stall_if_idle", {31'b0, bus.stallreq_if_o}, 32'd1);
        @(negedge clk);
        check("cont fetch_ce", {31'b0, bus.ram_ce_o}, 32'd1);
        check("cont fetch_addr", bus.ram_addr_o, 32'h600);
        bus.ram_data_ready = 1'b1; bus.ram_data_i = 32'h3333_4444;
        @(negedge clk);
        check("cont i_done", {31'b0, bus.i_done_o}, 32'd1);
        check("cont i_data", bus.i_data_o, 32'h3333_4444);
        check("cont d_data_kept", bus.d_data_o, 32'h1111_2222);
        check("cont stall_if_cleared", {31'b0, bus.stallreq_if_o}, 32'd0);
        bus.i_ce_i = 1'b0; bus.ram_data_ready = 1'b0;
        @(negedge clk);

        // Requester drops ce mid-transaction: the access still completes.
        bus.d_ce_i = 1'b1; bus.d_addr_i = 32'h700;
        @(negedge clk);
        check("drop ce_granted", {31'b0, bus.ram_ce_o}, 32'd1);
        bus.d_ce_i = 1'b0;
        @(negedge clk);
        check("drop ce_held", {31'b0, bus.ram_ce_o}, 32'd1);
        bus.ram_data_ready = 1'b1; bus.ram_data_i = 32'h7777_8888;
        @(negedge clk);
        check("drop d_done", {31'b0, bus.d_done_o}, 32'd1);
        check("drop d_data", bus.d_data_o, 32'h7777_8888);
        bus.ram_data_ready = 1'b0;
        @(negedge clk);
        check("drop done_cleared", {31'b0, bus.d_done_o}, 32'd0);

        // Starvation: both held, RAM always ready; expect 4 data grants per fetch grant.
        bus.d_ce_i = 1'b1; bus.d_we_i = 1'b0; bus.d_addr_i = 32'h300;
        bus.i_ce_i = 1'b1; bus.i_addr_i = 32'h400;
        bus.ram_data_ready = 1'b1; bus.ram_data_i = 32'h0;
        run1 = 0; run2 = 0; fetches = 0; prev_ce = 1'b0;
        for (int c = 0; c < 80 && fetches < 2; c++) begin
            @(negedge clk);
            if (bus.ram_ce_o && !prev_ce) begin
                if (bus.ram_addr_o == 32'h400) fetches++;
                else if (fetches == 0)         run1++;
                else                           run2++;
            end
            prev_ce = bus.ram_ce_o;
        end
        bus.d_ce_i = 1'b0; bus.i_ce_i = 1'b0;
        check("starve fetch_grants", fetches, 2);
        check("starve first_data_run", run1, 4);
        check("starve second_data_run", run2, 4);
        repeat (2) @(negedge clk);
        bus.ram_data_ready = 1'b0;
        @(negedge clk);

        // Reset while a fetch is in flight: abandoned, no done, later ready ignored.
        bus.i_ce_i = 1'b1; bus.i_addr_i = 32'h800;
        @(negedge clk);
        check("rstmid busy_ce", {31'b0, bus.ram_ce_o}, 32'd1);
        rst = 1'b1; bus.i_ce_i = 1'b0;
        @(negedge clk);
        check("rstmid ram_ce", {31'b0, bus.ram_ce_o}, 32'd0);
        check("rstmid i_done", {31'b0, bus.i_done_o}, 32'd0);
        check("rstmid ram_addr", bus.ram_addr_o, 32'd0);
        check("rstmid i_data", bus.i_data_o, 32'd0);
        rst = 1'b0;
        bus.ram_data_ready = 1'b1; bus.ram_data_i = 32'h9999_9999;
        stray = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.i_done_o || bus.d_done_o || bus.ram_ce_o) stray++;
        end
        check("rstmid stray_activity", stray, 0);
        check("rstmid i_data_kept", bus.i_data_o, 32'd0);
        bus.ram_data_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
